seq_pattern_detector: RTL
=========================

# seq_pattern_detector

Parametrised serial pattern detector for the bit-stream monitoring path. It matches a runtime-programmable pattern of 1..MAX_LEN bits, supports overlapping and non-overlapping match modes, and qualifies input bits with a valid strobe. It produces a registered single-cycle detect pulse and a saturating match counter. It replaces fixed-pattern, fixed-length detectors: the default configuration detects "110" with overlap enabled.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be >= 2.
- CNT_W, 16: width of match counter.
- DEF_PATTERN, 8'b0000_0110: pattern after reset, right-aligned.
- DEF_LEN, 3: pattern length after reset.
- DEF_OVERLAP, 1: overlap mode after reset.
- LW (derived): $clog2(MAX_LEN+1).

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cfg_load  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is first-received bit, bit [0] last
- cfg_len  in  LW  pattern length, valid range 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_err  out  1  one-cycle pulse: cfg_load rejected
- in_valid  in  1  in_bit is sampled this cycle
- in_bit  in  1  serial data bit
- cnt_clr  in  1  clear match counter
- det_pulse  out  1  one-cycle pulse on match
- det_count  out  CNT_W  saturating count of matches

## Operation
- State: pattern reg, len reg, overlap reg, history shift reg hist[MAX_LEN-1:0] (hist[0] newest), fill counter (0..MAX_LEN, bits received since last clear), det_count.
- Accepted bit (in_valid=1, cfg_load=0): hist <= {hist[MAX_LEN-2:0], in_bit}; fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on post-shift values: fill_next >= len AND hist_next[len-1:0] == pattern[len-1:0]. Bits above len are ignored.
- On match: det_pulse <= 1; det_count increments, saturating at 2^CNT_W-1.
- Overlap=1: history is retained after a match; suffix bits may start the next match.
- Overlap=0: fill <= 0 on match. A new match requires len fresh bits.
- in_valid=0: hist, fill unchanged; det_pulse <= 0.
- cfg_load with 1 <= cfg_len <= MAX_LEN: pattern/len/overlap loaded; hist <= 0; fill <= 0; det_pulse <= 0; det_count unchanged.
- cfg_load with cfg_len == 0 or > MAX_LEN: configuration unchanged; cfg_err <= 1 for one cycle; hist and fill are still cleared.
- cnt_clr: det_count <= 0. If a match occurs in the same cycle, det_count <= 1.
- Priority: rst > cfg_load > in_valid data path. A bit presented with cfg_load is discarded.

## Timing
- Reset values: det_pulse=0, det_count=0, cfg_err=0, hist=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
- Latency: if the final pattern bit is sampled at edge N, det_pulse is high from edge N until edge N+1. det_count reflects the increment after edge N.
- det_pulse and cfg_err are fully registered. There are no negedge or combinational outputs.
- Back-to-back matches are allowed (overlap=1, e.g. pattern "11"). det_pulse stays high for consecutive edges, one pulse per match.
- Reset mid-stream: partial history is lost. The first match possible after reset needs len valid bits.
- Config takes effect for bits sampled on the edge after the load edge.

## Test plan
- Default config after reset, stream 0,1,1,0,1,1,0 (in_valid=1): det_pulse high exactly after the 4th and 7th bit edges; det_count=2.
- Load pattern 2'b11, len=2, overlap=1, stream 1,1,1,1: 3 pulses, on bits 2, 3 and 4. Reload with overlap=0, same stream: 2 pulses, on bits 2 and 4.
- in_valid gaps: pattern 110 with idle cycles between each bit: one pulse on the cycle after the final 0 is sampled; no pulse during idle cycles.
- cfg_load with cfg_len=0, then with cfg_len=MAX_LEN+1: cfg_err pulses once each; the prior pattern still detects afterwards.
- CNT_W=2, pattern "1" len 1, five 1s: det_count goes 1,2,3,3,3. Then cnt_clr together with a matching bit: det_count=1.
- cfg_load asserted with the final matching bit, and rst asserted mid-pattern: no det_pulse in either case; outputs take reset values.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
//
// Serial pattern detector for the bit-stream monitoring path. Matches a
// runtime-programmable pattern of 1..MAX_LEN bits against the most recent
// valid input bits. Supports overlapping and non-overlapping match modes.
// Produces a registered single-cycle detect pulse and a saturating match
// counter.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   cfg_load     load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  pattern, right-aligned; bit [len-1] is received first
//   cfg_len      pattern length, legal range 1..MAX_LEN
//   cfg_overlap  1 = a match's suffix may start the next match
//   cfg_err      one-cycle pulse when a cfg_load was rejected
//   in_valid     in_bit is sampled this cycle
//   in_bit       serial data bit
//   cnt_clr      clear the match counter
//   det_pulse    one-cycle pulse per match
//   det_count    saturating match count
// ---------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(6),
  parameter int                 DEF_LEN     = 3,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clr,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   det_count
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LW-1:0]      len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LW-1:0]      fill_q;

  logic [MAX_LEN-1:0] hist_next;
  logic [LW-1:0]      fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               accept;
  logic               match;
  logic               cfg_ok;

  // The oldest history bit is shifted out every accepted bit and is never
  // compared, since len never exceeds MAX_LEN.
  logic hist_msb_unused;
  assign hist_msb_unused = hist_q[MAX_LEN-1];

  always_comb begin
    accept    = in_valid & ~cfg_load;
    hist_next = {hist_q[MAX_LEN-2:0], in_bit};
    fill_next = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

    // Bits at or above len are don't-care in the compare.
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    // Match is judged on the post-shift history so the pulse lines up with
    // the edge that samples the final pattern bit.
    match = accept && (fill_next >= len_q) &&
            ((hist_next & len_mask) == (pattern_q & len_mask));

    cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LW'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      det_pulse <= 1'b0;
      cfg_err   <= 1'b0;
      det_count <= '0;
    end else begin
      det_pulse <= match;
      cfg_err   <= 1'b0;

      if (cfg_load) begin
        if (cfg_ok) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          overlap_q <= cfg_overlap;
        end else begin
          cfg_err <= 1'b1;
        end
        // History is flushed even on a rejected load so the stream restarts
        // cleanly from a known point.
        hist_q <= '0;
        fill_q <= '0;
      end else if (in_valid) begin
        hist_q <= hist_next;
        // Non-overlap mode: forget all bits consumed by this match.
        fill_q <= (match && !overlap_q) ? '0 : fill_next;
      end

      if (cnt_clr) begin
        det_count <= match ? CNT_W'(1) : '0;
      end else if (match && (det_count != '1)) begin
        det_count <= det_count + CNT_W'(1);
      end
    end
  end

endmodule
